// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller.
//   DEFAULT_WIDTH : default operand/result width in bits
//   state_t       : controller state encoding (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell.
//   a, b, c : input bits (c is the carry-in)
//   sum     : a ^ b ^ c
//   carry   : carry-out
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first,
// through a single full_adder cell.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : high whenever the controller is not in IDLE
//   dbg_state           : current FSM state encoding, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready/out_valid/busy are decoded from the registered state
// only, so neither depends combinationally on in_valid or out_ready. A
// producer may hold valid while ready is low; nothing is lost or repeated.
//
// Timing: operands accepted on edge k appear with out_valid after edge
// k+WIDTH. The result is held in DONE until out_ready is sampled high, and
// sum/cout then stay visible in IDLE until the next accept clears them.
// ---------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] b_q,         b_d;
   logic [WIDTH-1:0] sum_q,       sum_d;
   logic             carry_q,     carry_d;
   logic             cout_q,      cout_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q,      busy_d;

   logic             fa_sum;
   logic             fa_carry;
   logic [WIDTH:0]   sum_shift;

   full_adder u_fa (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .c     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
   // Built as a WIDTH+1 vector so the slice stays legal for WIDTH=1.
   assign sum_shift = {fa_sum, sum_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = sum_shift[WIDTH:1];
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_carry;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               cout_d  = fa_carry;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Handshake outputs are registered decodes of the next state.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
// Bench for serial_add_ctrl at WIDTH=8 and WIDTH=1. The expected result of
// every operation is plain integer addition a+b+cin, queued at accept time
// and popped when the result is delivered.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT WIDTH=8 ----------------
   logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
   logic [7:0] a8, b8, sum8;
   logic [1:0] state8;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .cin       (cin8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum       (sum8),
      .cout      (cout8),
      .busy      (busy8),
      .dbg_state (state8)
   );

   // ---------------- DUT WIDTH=1 ----------------
   logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
   logic [0:0] a1, b1, sum1;
   logic [1:0] state1;

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .cin       (cin1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .cout      (cout1),
      .busy      (busy1),
      .dbg_state (state1)
   );

   // ---------------- scoreboard ----------------
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [8:0]  exp_q[$];   // {cout, sum} for the WIDTH=8 instance

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: plain integer addition.
   function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
      int unsigned s;
      s = int'(x) + int'(y) + int'(c);
      return s[8:0];
   endfunction

   // ---------------- driver tasks ----------------
   // All driving and sampling happens 1 time unit after a rising edge.

   // One WIDTH=8 operation: accept, check latency, hold DONE for `stall`
   // cycles (optionally waving junk in_valid), then release.
   task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input int stall, input bit junk);
      int guard;
      int lat;
      logic [8:0] exp;
      guard = 0;
      while (!in_ready8 && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      check("ready_wait", 64'(guard < 50), 64'd1);
      a8 = ta; b8 = tb_v; cin8 = tc; in_valid8 = 1'b1;
      out_ready8 = 1'b0;
      @(posedge clk); #1;                       // accept edge
      exp_q.push_back(ref_add8(ta, tb_v, tc));
      lat = 0;
      while (!out_valid8 && lat < 50) begin
         // operands and in_valid change freely during RUN
         in_valid8 = 1'($urandom_range(0, 1));
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         @(posedge clk); #1; lat++;
      end
      check("latency", 64'(lat), 64'd8);
      exp = exp_q.pop_front();
      check("sum", 64'(sum8), 64'(exp[7:0]));
      check("cout", 64'(cout8), 64'(exp[8]));
      for (int i = 0; i < stall; i++) begin
         if (junk) begin
            in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         end
         @(posedge clk); #1;
         check("stall_valid", 64'(out_valid8), 64'd1);
         check("stall_ready", 64'(in_ready8), 64'd0);
         check("stall_sum", 64'({cout8, sum8}), 64'(exp));
      end
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      @(posedge clk); #1;                       // deliver edge
      out_ready8 = 1'b0;
      check("rel_valid", 64'(out_valid8), 64'd0);
      check("rel_ready", 64'(in_ready8), 64'd1);
      check("rel_hold", 64'({cout8, sum8}), 64'(exp));
   endtask

   task automatic run_op1(input logic ta, input logic tb_v, input logic tc);
      int lat;
      int unsigned exp;
      exp = int'(ta) + int'(tb_v) + int'(tc);
      a1 = ta; b1 = tb_v; cin1 = tc; in_valid1 = 1'b1; out_ready1 = 1'b0;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check("w1_latency", 64'(lat), 64'd1);
      check("w1_result", 64'({cout1, sum1}), 64'(exp));
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      check("w1_ready", 64'(in_ready1), 64'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] ra, rb;
      logic       rc;

      rst_n = 1'b0;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready8), 64'd1);
      check("rst_out_valid", 64'(out_valid8), 64'd0);
      check("rst_busy", 64'(busy8), 64'd0);
      check("rst_sum", 64'({cout8, sum8}), 64'd0);
      check("rst_state", 64'(state8), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed WIDTH=8 cases
      run_op8(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
      run_op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      run_op8(8'hFF, 8'hFF, 1'b1, 1, 1'b0);
      run_op8(8'h00, 8'h00, 1'b0, 0, 1'b0);
      run_op8(8'h00, 8'h00, 1'b1, 0, 1'b0);

      // backpressure with junk offers, then a clean accept
      run_op8(8'h12, 8'h34, 1'b1, 5, 1'b1);
      check("idle_busy", 64'(busy8), 64'd0);
      run_op8(8'h80, 8'h80, 1'b0, 0, 1'b0);

      // reset mid-RUN after four bits of 0xAA + 0x55
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("mid_busy", 64'(busy8), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_valid", 64'(out_valid8), 64'd0);
      check("abort_sum", 64'({cout8, sum8}), 64'd0);
      check("abort_state", 64'(state8), 64'd0);
      check("abort_ready", 64'(in_ready8), 64'd1);
      check("abort_busy", 64'(busy8), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("abort_no_result", 64'(out_valid8), 64'd0);
      end
      run_op8(8'h01, 8'h01, 1'b0, 0, 1'b0);

      // WIDTH=1: all operand combinations
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         run_op1(v[2], v[1], v[0]);
      end

      // random stream with random stalls
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         run_op8(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operand set on a, b, cin is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  addend A.
REQ-007 b  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  sum and cout hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  result bits (a+b+cin) mod 2^WIDTH.
REQ-012 cout  output  1  carry-out of the MSB.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL compute a+b+cin bit-serially, LSB first, using exactly one 1-bit full-adder cell, one bit per clock.
REQ-015 FSM states SHALL be IDLE, RUN and DONE; no other reachable states.
REQ-016 IDLE: in_ready=1, out_valid=0. On rising edge with in_valid=1, the block SHALL capture a and b into shift registers, set the carry flop to cin, clear bit counter, clear the sum register, and go to RUN.
REQ-017 RUN: in_ready=0, out_valid=0. Each cycle, the adder SHALL be fed with LSB(A shift reg), LSB(B shift reg) and the carry flop. The sum bit SHALL shift into the MSB of the sum register (right shift), the operands SHALL shift right by one, carry flop <= adder carry, and counter SHALL increment.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1, the state SHALL go to DONE and cout SHALL take the final carry.
REQ-019 Latency: accept edge k -> out_valid high after edge k+WIDTH.
REQ-020 DONE: out_valid=1, in_ready=0. sum and cout SHALL hold stable until out_ready=1 is sampled; then the state SHALL go to IDLE.
REQ-021 sum and cout SHALL retain the last result in IDLE until the next accept clears the sum register.
REQ-022 in_valid is ignored outside IDLE; a, b and cin changes during RUN/DONE SHALL NOT affect the result.
REQ-023 Throughput: at most one operation per WIDTH+2 cycles, with no overlap of accept and deliver.
REQ-024 Counter width SHALL be clog2(WIDTH+1); for WIDTH=1, RUN SHALL last one cycle.
REQ-025 out_valid, in_ready and busy SHALL be registered-state decodes with no combinational path from in_valid or out_ready.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry flop=0, counter=0, and clear the operand shift registers.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no result delivered. The first accept after rst_n rises SHALL proceed normally.
REQ-028 Reset deassertion SHALL take effect at the next rising clk; no accept occurs on the deassertion edge when rst_n is still low at sampling.

Structure
REQ-029 A shared package serial_add_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-030 The 1-bit adder SHALL be the existing full_adder cell (ports a, b, c, sum, carry), instantiated exactly once as sub-module u_fa. No other sub-modules.
REQ-031 Target RTL size is 120-400 lines, with no memories and no multipliers.

Verification
REQ-032 WIDTH=8: a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid 8 cycles after accept, sum=0x96, cout=0.
REQ-033 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and sum stable and in_ready=0 throughout. Drive in_valid=1 with new operands meanwhile -> not accepted. Release -> IDLE next cycle, then new operands are accepted.
REQ-035 Reset mid-RUN (after bit 3 of a=0xAA, b=0x55) -> out_valid, sum, cout immediately 0, and state IDLE. The next op 0x01+0x01 -> sum=0x02.
REQ-036 WIDTH=1: all 8 combinations of a, b, cin -> {cout,sum} equals a+b+cin, with out_valid one cycle after accept.
REQ-037 A random back-to-back stream of 1000 ops with random out_ready stalls SHALL match a scoreboard computing (a+b+cin) with zero mismatches.
